// File: rtl/instr_type_pkg.sv
// Decode instruction type codes and default fetch addresses shared by
// the decode stage and the PC generator.
package instr_type_pkg;

  typedef enum logic [9:0] {
    IT_OTHER = 10'd0,
    IT_BEQ   = 10'd1,
    IT_BNE   = 10'd2,
    IT_J     = 10'd3,
    IT_JAL   = 10'd4,
    IT_JR    = 10'd5,
    IT_JALR  = 10'd6
  } instr_type_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEFAULT   = 32'h0000_4180;

endpackage

// File: rtl/pc_gen_target.sv
// Combinational next-fetch target and delay-slot flag for the decode-stage
// instruction, based on the current fetch PC (decode PC + 4).
module pc_gen_target
  import instr_type_pkg::*;
#(
  parameter bit JX_EN = 1'b1
) (
  input  logic [31:0] F_PC,
  input  logic [9:0]  D_instrType,
  input  logic        D_isBranch,
  input  logic [25:0] D_imm,
  input  logic [31:0] D_RD1,
  output logic [31:0] target,
  output logic        ctrl
);

  logic [31:0] d_pc;
  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] jmp_pc;

  always_comb begin
    d_pc   = F_PC - 32'd4;
    seq_pc = F_PC + 32'd4;
    br_pc  = F_PC + {{14{D_imm[15]}}, D_imm[15:0], 2'b00};
    jmp_pc = (d_pc & 32'hF000_0000) | {4'b0000, D_imm, 2'b00};
    target = seq_pc;
    ctrl   = 1'b0;
    case (D_instrType)
      IT_BEQ, IT_BNE: begin
        ctrl = 1'b1;
        if (D_isBranch) target = br_pc;
      end
      IT_JAL: begin
        ctrl   = 1'b1;
        target = jmp_pc;
      end
      IT_J: begin
        if (JX_EN) begin
          ctrl   = 1'b1;
          target = jmp_pc;
        end
      end
      IT_JR: begin
        ctrl   = 1'b1;
        target = D_RD1;
      end
      IT_JALR: begin
        if (JX_EN) begin
          ctrl   = 1'b1;
          target = D_RD1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with exception/eret/stall priority, delay-slot tracking
// and fetch address-error detection.
module pc_gen
  import instr_type_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_PC    = EXC_PC_DEFAULT,
  parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
  parameter logic [31:0] IMEM_SIZE = 32'h0000_4000,
  parameter bit          JX_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_stall,
  input  logic        M_excReq,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  input  logic        D_isBranch,
  input  logic [9:0]  D_instrType,
  input  logic [25:0] D_imm,
  input  logic [31:0] D_RD1,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC8,
  output logic        F_BD,
  output logic        F_excAdEL,
  output logic        D_eretFlush
);

  // 33-bit exclusive upper bound so a window ending at 2^32 cannot wrap
  localparam logic [32:0] WIN_LO = {1'b0, IMEM_BASE};
  localparam logic [32:0] WIN_HI = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

  logic [31:0] target;
  logic        ctrl;
  logic        in_win;

  pc_gen_target #(
    .JX_EN(JX_EN)
  ) u_target (
    .F_PC        (F_PC),
    .D_instrType (D_instrType),
    .D_isBranch  (D_isBranch),
    .D_imm       (D_imm),
    .D_RD1       (D_RD1),
    .target      (target),
    .ctrl        (ctrl)
  );

  always_comb begin
    D_PC8       = F_PC + 32'd4;
    in_win      = ({1'b0, F_PC} >= WIN_LO) && ({1'b0, F_PC} < WIN_HI);
    F_excAdEL   = ~reset & ((F_PC[1:0] != 2'b00) | ~in_win);
    D_eretFlush = D_eret & ~M_excReq & ~D_stall & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      F_PC <= RESET_PC;
      F_BD <= 1'b0;
    end else if (M_excReq) begin
      F_PC <= EXC_PC;
      F_BD <= 1'b0;
    end else if (D_eret && !D_stall) begin
      F_PC <= EPC;
      F_BD <= 1'b0;
    end else if (!D_stall) begin
      F_PC <= target;
      F_BD <= ctrl;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// against a behavioural next-PC model.
module tb_pc_gen;
  import instr_type_pkg::*;

  logic        clk;
  logic        reset;
  logic        D_stall;
  logic        M_excReq;
  logic        D_eret;
  logic [31:0] EPC;
  logic        D_isBranch;
  logic [9:0]  D_instrType;
  logic [25:0] D_imm;
  logic [31:0] D_RD1;
  logic [31:0] F_PC;
  logic [31:0] D_PC8;
  logic        F_BD;
  logic        F_excAdEL;
  logic        D_eretFlush;

  int unsigned passed;
  int unsigned total;
  logic [31:0] m_pc;
  logic        m_bd;

  pc_gen #(
    .RESET_PC  (32'h0000_3000),
    .EXC_PC    (32'h0000_4180),
    .IMEM_BASE (32'h0000_3000),
    .IMEM_SIZE (32'h0000_4000),
    .JX_EN     (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .D_stall     (D_stall),
    .M_excReq    (M_excReq),
    .D_eret      (D_eret),
    .EPC         (EPC),
    .D_isBranch  (D_isBranch),
    .D_instrType (D_instrType),
    .D_imm       (D_imm),
    .D_RD1       (D_RD1),
    .F_PC        (F_PC),
    .D_PC8       (D_PC8),
    .F_BD        (F_BD),
    .F_excAdEL   (F_excAdEL),
    .D_eretFlush (D_eretFlush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_target(logic [31:0] pc, logic [9:0] ty,
                                             logic br, logic [25:0] imm,
                                             logic [31:0] rd1);
    int off;
    off = int'($signed(imm[15:0])) * 4;
    if (ty == IT_BEQ || ty == IT_BNE) return br ? pc + 32'(off) : pc + 32'd4;
    if (ty == IT_J || ty == IT_JAL)   return ((pc - 32'd4) & 32'hF000_0000) | (32'(imm) << 2);
    if (ty == IT_JR || ty == IT_JALR) return rd1;
    return pc + 32'd4;
  endfunction

  function automatic logic ref_slot(logic [9:0] ty);
    return ty inside {IT_BEQ, IT_BNE, IT_J, IT_JAL, IT_JR, IT_JALR};
  endfunction

  function automatic logic ref_adel(logic [31:0] pc, logic rst);
    return !rst && (pc[1:0] != 2'b00 || pc < 32'h3000 || pc > 32'h6FFF);
  endfunction

  // Advance one clock and move the model by the same rules.
  task automatic step();
    logic [31:0] npc;
    logic        nbd;
    npc = m_pc;
    nbd = m_bd;
    if (reset)                  begin npc = 32'h3000; nbd = 1'b0; end
    else if (M_excReq)          begin npc = 32'h4180; nbd = 1'b0; end
    else if (D_eret && !D_stall) begin npc = EPC;      nbd = 1'b0; end
    else if (!D_stall) begin
      npc = ref_target(m_pc, D_instrType, D_isBranch, D_imm, D_RD1);
      nbd = ref_slot(D_instrType);
    end
    @(posedge clk);
    #1;
    m_pc = npc;
    m_bd = nbd;
  endtask

  task automatic idle();
    reset = 1'b0; D_stall = 1'b0; M_excReq = 1'b0; D_eret = 1'b0;
    EPC = 32'h0; D_isBranch = 1'b0; D_instrType = IT_OTHER;
    D_imm = '0; D_RD1 = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    D_eret = 1'b1;
    M_excReq = 1'b1;
    step();
    step();
    #1;
    total++; if (F_PC !== 32'h3000) $display("FAIL reset_pc: got %h want %h", F_PC, 32'h3000); else passed++;
    total++; if (F_BD !== 1'b0) $display("FAIL reset_bd: got %b want 0", F_BD); else passed++;
    total++; if (D_eretFlush !== 1'b0) $display("FAIL reset_flush: got %b want 0", D_eretFlush); else passed++;
    total++; if (F_excAdEL !== 1'b0) $display("FAIL reset_adel: got %b want 0", F_excAdEL); else passed++;
    idle();
    step();
    total++; if (F_PC !== 32'h3004 || F_BD !== 1'b0) $display("FAIL idle1: got %h/%b want 00003004/0", F_PC, F_BD); else passed++;
    step();
    total++; if (F_PC !== 32'h3008 || F_BD !== 1'b0) $display("FAIL idle2: got %h/%b want 00003008/0", F_PC, F_BD); else passed++;
  endtask

  task automatic test_branch();
    idle();
    D_instrType = IT_BEQ; D_isBranch = 1'b1; D_imm = 26'h000FFFE;
    step();
    total++; if (F_PC !== 32'h3000 || F_BD !== 1'b1) $display("FAIL beq_taken: got %h/%b want 00003000/1", F_PC, F_BD); else passed++;
    idle();
    step();
    step();
    D_instrType = IT_BEQ; D_isBranch = 1'b0; D_imm = 26'h000FFFE;
    step();
    total++; if (F_PC !== 32'h300C || F_BD !== 1'b1) $display("FAIL beq_not_taken: got %h/%b want 0000300c/1", F_PC, F_BD); else passed++;
  endtask

  task automatic test_jump();
    idle();
    D_instrType = IT_JR; D_RD1 = 32'h3010;
    step();
    D_instrType = IT_JAL; D_imm = 26'h0000C40;
    #1;
    total++; if (D_PC8 !== 32'h3014) $display("FAIL jal_link: got %h want %h", D_PC8, 32'h3014); else passed++;
    step();
    total++; if (F_PC !== 32'h3100 || F_BD !== 1'b1) $display("FAIL jal_target: got %h/%b want 00003100/1", F_PC, F_BD); else passed++;
    D_instrType = IT_JR; D_RD1 = 32'h3002;
    step();
    total++; if (F_PC !== 32'h3002) $display("FAIL jr_misaligned: got %h want %h", F_PC, 32'h3002); else passed++;
    total++; if (F_excAdEL !== 1'b1) $display("FAIL adel_misaligned: got %b want 1", F_excAdEL); else passed++;
  endtask

  task automatic test_stall();
    idle();
    D_instrType = IT_JR; D_RD1 = 32'h3040; D_stall = 1'b1;
    step();
    total++; if (F_PC !== 32'h3002 || F_BD !== 1'b1) $display("FAIL stall1: got %h/%b want 00003002/1", F_PC, F_BD); else passed++;
    step();
    total++; if (F_PC !== 32'h3002 || F_BD !== 1'b1) $display("FAIL stall2: got %h/%b want 00003002/1", F_PC, F_BD); else passed++;
    D_stall = 1'b0;
    step();
    total++; if (F_PC !== 32'h3040 || F_BD !== 1'b1) $display("FAIL stall_release: got %h/%b want 00003040/1", F_PC, F_BD); else passed++;
  endtask

  task automatic test_exc_eret();
    idle();
    M_excReq = 1'b1; D_eret = 1'b1; D_stall = 1'b1; EPC = 32'h3020;
    #1;
    total++; if (D_eretFlush !== 1'b0) $display("FAIL exc_flush: got %b want 0", D_eretFlush); else passed++;
    step();
    total++; if (F_PC !== 32'h4180 || F_BD !== 1'b0) $display("FAIL exc_redirect: got %h/%b want 00004180/0", F_PC, F_BD); else passed++;
    M_excReq = 1'b0;
    #1;
    total++; if (D_eretFlush !== 1'b0) $display("FAIL eret_stall_flush: got %b want 0", D_eretFlush); else passed++;
    step();
    total++; if (F_PC !== 32'h4180) $display("FAIL eret_stall_hold: got %h want %h", F_PC, 32'h4180); else passed++;
    D_stall = 1'b0;
    #1;
    total++; if (D_eretFlush !== 1'b1) $display("FAIL eret_flush: got %b want 1", D_eretFlush); else passed++;
    step();
    total++; if (F_PC !== 32'h3020 || F_BD !== 1'b0) $display("FAIL eret_redirect: got %h/%b want 00003020/0", F_PC, F_BD); else passed++;
  endtask

  task automatic test_bounds();
    idle();
    D_instrType = IT_JR; D_RD1 = 32'h2FFC;
    step();
    total++; if (F_excAdEL !== 1'b1) $display("FAIL adel_below: got %b want 1", F_excAdEL); else passed++;
    D_RD1 = 32'h6FFC;
    step();
    total++; if (F_excAdEL !== 1'b0) $display("FAIL adel_top: got %b want 0", F_excAdEL); else passed++;
    idle();
    step();
    total++; if (F_PC !== 32'h7000 || F_excAdEL !== 1'b1) $display("FAIL adel_above: got %h/%b want 00007000/1", F_PC, F_excAdEL); else passed++;
    step();
    total++; if (F_PC !== 32'h7004) $display("FAIL fault_advance: got %h want %h", F_PC, 32'h7004); else passed++;
    reset = 1'b1; M_excReq = 1'b1;
    step();
    total++; if (F_PC !== 32'h3000 || F_BD !== 1'b0) $display("FAIL reset_over_exc: got %h/%b want 00003000/0", F_PC, F_BD); else passed++;
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      D_stall     = ($urandom_range(0, 3) == 0);
      M_excReq    = ($urandom_range(0, 15) == 0);
      D_eret      = ($urandom_range(0, 7) == 0);
      EPC         = 32'h3000 + ($urandom_range(0, 4095) << 2);
      D_isBranch  = 1'($urandom);
      D_instrType = ($urandom_range(0, 7) == 7) ? 10'($urandom) : 10'($urandom_range(0, 6));
      D_imm       = 26'($urandom);
      D_RD1       = $urandom_range(0, 1) ? 32'h3000 + ($urandom_range(0, 4095) << 2) : $urandom;
      #1;
      total++; if (D_eretFlush !== (D_eret && !M_excReq && !D_stall && !reset))
        $display("FAIL rnd_flush[%0d]: got %b want %b", i, D_eretFlush, D_eret && !M_excReq && !D_stall && !reset); else passed++;
      total++; if (F_excAdEL !== ref_adel(m_pc, reset))
        $display("FAIL rnd_adel[%0d]: got %b want %b (pc %h)", i, F_excAdEL, ref_adel(m_pc, reset), m_pc); else passed++;
      total++; if (D_PC8 !== m_pc + 32'd4)
        $display("FAIL rnd_link[%0d]: got %h want %h", i, D_PC8, m_pc + 32'd4); else passed++;
      step();
      total++; if (F_PC !== m_pc || F_BD !== m_bd)
        $display("FAIL rnd_pc[%0d]: got %h/%b want %h/%b", i, F_PC, F_BD, m_pc, m_bd); else passed++;
    end
    idle();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    m_pc   = 32'h0;
    m_bd   = 1'b0;
    idle();
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_exc_eret();
    test_bounds();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded by reset.
REQ-002 Parameter EXC_PC, default 32'h0000_4180, exception handler entry address.
REQ-003 Parameter IMEM_BASE, default 32'h0000_3000, lowest legal fetch address.
REQ-004 Parameter IMEM_SIZE, default 32'h0000_4000, legal fetch window size in bytes.
REQ-005 Parameter JX_EN, default 1, enables the j and jalr instruction types; 0 treats them as sequential.
REQ-006 clk  input  1  clock; one clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 D_stall  input  1  hazard stall; holds fetch state.
REQ-009 M_excReq  input  1  exception taken this cycle; redirect to EXC_PC.
REQ-010 D_eret  input  1  eret in decode; redirect to EPC.
REQ-011 EPC  input  32  return address for eret.
REQ-012 D_isBranch  input  1  branch condition true for the decode instruction.
REQ-013 D_instrType  input  10  decode instruction type code (shared package).
REQ-014 D_imm  input  26  decode immediate / jump index.
REQ-015 D_RD1  input  32  forwarded rs value (jr, jalr target).
REQ-016 F_PC  output  32  current fetch PC (registered).
REQ-017 D_PC8  output  32  link value, F_PC + 4 (decode PC + 8).
REQ-018 F_BD  output  1  fetched instruction sits in a delay slot (registered).
REQ-019 F_excAdEL  output  1  fetch address error for F_PC.
REQ-020 D_eretFlush  output  1  kill the fetch-stage instruction (eret has no delay slot).

Function
REQ-021 Decode PC SHALL be F_PC - 4; all targets use 32-bit wrap-around arithmetic.
REQ-022 beq/bne SHALL target F_PC + sign-extended D_imm[15:0]<<2 when D_isBranch=1, else F_PC + 4.
REQ-023 jal (and j when JX_EN=1) SHALL target {D_PC[31:28], D_imm, 2'b00}.
REQ-024 jr (and jalr when JX_EN=1) SHALL target D_RD1 unmodified, misaligned values included.
REQ-025 All other types SHALL target F_PC + 4.
REQ-026 Next-state priority SHALL be reset > M_excReq > D_eret > D_stall > normal target.
REQ-027 M_excReq=1 SHALL load F_PC=EXC_PC and F_BD=0 next cycle, regardless of D_stall or D_eret.
REQ-028 D_eret=1 (no M_excReq) SHALL load F_PC=EPC and F_BD=0, and assert D_eretFlush combinationally the same cycle.
REQ-029 D_eret=1 with D_stall=1 SHALL hold F_PC and F_BD and deassert D_eretFlush; the redirect occurs on the first unstalled cycle.
REQ-030 D_stall=1 alone SHALL hold F_PC and F_BD unchanged.
REQ-031 Normal advance SHALL set F_BD=1 when D_instrType is beq, bne, jal, jr (or j, jalr with JX_EN=1), taken or not; otherwise 0.
REQ-032 F_excAdEL SHALL be combinational: 1 when F_PC[1:0]!=0 or F_PC outside [IMEM_BASE, IMEM_BASE+IMEM_SIZE-1].
REQ-033 The window upper bound SHALL be computed at 33 bits, so IMEM_BASE+IMEM_SIZE never wraps.
REQ-034 A faulting F_PC SHALL still advance normally; redirection is left to M_excReq.

Reset
REQ-035 Reset SHALL set F_PC=RESET_PC, F_BD=0, D_eretFlush=0 and F_excAdEL=0, overriding every other input.
REQ-036 Reset asserted mid-stall or mid-redirect SHALL discard the pending action; the next cycle fetches RESET_PC.

Structure
REQ-037 Instruction type codes and the default RESET_PC/EXC_PC constants SHALL live in shared package instr_type_pkg.
REQ-038 Target calculation SHALL be a combinational sub-module pc_gen_target; pc_gen holds the registers, priority and fault logic.

Verification
REQ-039 Reset, then 3 idle cycles with type=other -> F_PC 0x3000, 0x3004, 0x3008; F_BD=0.
REQ-040 F_PC=0x3008, beq, D_isBranch=1, imm=0xFFFE -> F_PC=0x3000, F_BD=1; D_isBranch=0 -> F_PC=0x300C, F_BD=1.
REQ-041 F_PC=0x3010, jal imm=0x0000C40 -> F_PC=0x3100, D_PC8=0x3014; jr with D_RD1=0x3002 -> F_PC=0x3002, F_excAdEL=1.
REQ-042 D_stall=1 for 2 cycles with jr pending -> F_PC, F_BD held; the jump applies on the third cycle.
REQ-043 M_excReq=1 with D_eret=1 and D_stall=1 -> F_PC=0x4180, F_BD=0; next D_eret=1, EPC=0x3020 -> D_eretFlush=1, F_PC=0x3020.
REQ-044 F_PC=0x6FFC -> F_excAdEL=0; advance to 0x7000 -> F_excAdEL=1; reset asserted with M_excReq=1 -> F_PC=0x3000.
